// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch/decode definitions: instruction width, PC step, fetch FSM
// encoding and small helpers used across the front end.
package riscv_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

  // Canonical ADDI x0,x0,0; reserved for future bubble insertion.
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  function automatic logic is_word_aligned(input logic [1:0] lo);
    return (lo == 2'b00);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bus bundle: instruction memory request/response, decode-side
// instruction handshake, redirect input and fault flag.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 32
);
  import riscv_pkg::*;

  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [ADDR_W-1:0]  imem_req_addr;
  logic               imem_rsp_valid;
  logic [INSTR_W-1:0] imem_rsp_data;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr_out;
  logic [ADDR_W-1:0]  instr_pc;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_target;
  logic               fetch_fault;

  // Fetch unit side.
  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output instr_valid, instr_out, instr_pc,
    input  instr_ready, redirect_valid, redirect_target,
    output fetch_fault
  );

  // Memory / decode side.
  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  instr_valid, instr_out, instr_pc,
    output instr_ready, redirect_valid, redirect_target,
    input  fetch_fault
  );

endinterface

// File: rtl/instr_fetch_unit_fifo.sv
// Small synchronous FIFO with flush. Head is read combinationally from the
// storage array; storage itself is not reset, only the pointers are.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot a full FIFO would write into.
  assign do_push = push && (!full || do_pop) && !flush;
  assign head    = mem[rd_ptr[PTR_W-1:0]];

  // Pointer update; flush wins over push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Entry storage write.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word reads under a credit
// limit, tags each request with its PC, buffers returned words for decode
// and discards responses that belong to a fetch path abandoned by redirect.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                BUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  instr_fetch_unit_if.master bus
);

  localparam int CNT_W   = $clog2(BUF_DEPTH) + 1;
  localparam int SUM_W   = CNT_W + 1;
  localparam int ENTRY_W = INSTR_W + ADDR_W;

  fetch_state_t       state;
  logic               run_en;
  logic               fault_q;
  logic [ADDR_W-1:0]  pc;
  logic [CNT_W-1:0]   outstanding;
  logic [CNT_W-1:0]   outstanding_nxt;
  logic [CNT_W-1:0]   discard;
  logic [CNT_W-1:0]   fifo_count;
  logic [SUM_W-1:0]   credit_used;
  logic               fifo_full;
  logic               fifo_empty;
  logic               tag_full;
  logic               tag_empty;
  logic [ENTRY_W-1:0] head_entry;
  logic [ADDR_W-1:0]  rsp_pc;
  logic               req_fire;
  logic               rsp_fire;
  logic               rsp_keep;
  logic               hs_fire;
  logic               redirect_take;
  logic               redirect_bad;

  // Every in-flight request owns a FIFO slot, so the FIFO can never overflow.
  assign credit_used = SUM_W'(outstanding) + SUM_W'(fifo_count);

  assign bus.imem_req_valid = run_en && (state == RUN) && !tag_full &&
                              (credit_used < SUM_W'(BUF_DEPTH));
  assign bus.imem_req_addr  = pc;

  assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
  assign rsp_fire = bus.imem_rsp_valid && !tag_empty;

  // Responses are handled under the discard count in force at the start of
  // the cycle; a redirect in the same cycle flushes whatever gets pushed.
  assign rsp_keep = rsp_fire && (discard == '0) && (state == RUN) && !fifo_full;

  assign redirect_take = bus.redirect_valid && (state == RUN);
  assign redirect_bad  = redirect_take && !is_word_aligned(bus.redirect_target[1:0]);

  assign bus.instr_valid = (state == RUN) && !fifo_empty;
  assign hs_fire         = bus.instr_valid && bus.instr_ready;
  assign bus.instr_out   = bus.instr_valid ? head_entry[ENTRY_W-1 -: INSTR_W] : '0;
  assign bus.instr_pc    = bus.instr_valid ? head_entry[ADDR_W-1:0] : '0;
  assign bus.fetch_fault = fault_q;

  // Everything in flight after this cycle, including a request accepted now,
  // becomes stale when a redirect is taken.
  assign outstanding_nxt = outstanding + CNT_W'(req_fire) - CNT_W'(rsp_fire);

  // Fetch enable after reset, FSM and sticky misalignment fault.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_en  <= 1'b0;
      state   <= RUN;
      fault_q <= 1'b0;
    end else begin
      run_en <= 1'b1;
      if (redirect_bad) begin
        state   <= FAULT;
        fault_q <= 1'b1;
      end
    end
  end

  // Program counter: redirect overrides the sequential increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (redirect_take) begin
      pc <= bus.redirect_target;
    end else if (req_fire) begin
      pc <= pc + ADDR_W'(PC_STEP);
    end
  end

  // Count of responses still to be dropped after a redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      discard <= '0;
    end else if (redirect_take) begin
      discard <= outstanding_nxt;
    end else if (rsp_fire && (discard != '0)) begin
      discard <= discard - 1'b1;
    end
  end

  // PC tag queue; its occupancy is the outstanding-request count.
  fetch_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (BUF_DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (req_fire),
    .push_data (pc),
    .pop       (rsp_fire),
    .flush     (1'b0),
    .head      (rsp_pc),
    .count     (outstanding),
    .full      (tag_full),
    .empty     (tag_empty)
  );

  // Instruction buffer toward decode, flushed on any taken redirect.
  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (BUF_DEPTH)
  ) u_instr_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rsp_keep),
    .push_data ({bus.imem_rsp_data, rsp_pc}),
    .pop       (hs_fire),
    .flush     (redirect_take),
    .head      (head_entry),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: in-order latency-configurable memory model,
// a program-order stream model for requests and delivered instructions,
// directed scenarios followed by a randomized phase.
module tb_instr_fetch_unit;
  import riscv_pkg::*;

  localparam int          ADDR_W    = 32;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          BUF_DEPTH = 4;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          lat = 1;
  bit          rand_ready = 1'b0;
  logic        ready_force = 1'b1;
  mreq_t       mq[$];
  logic [31:0] exp_pc = RESET_PC;
  logic [31:0] exp_req = RESET_PC;
  bit          m_fault = 1'b0;
  int          n_consumed = 0;

  instr_fetch_unit_if #(.ADDR_W(ADDR_W)) bus ();

  instr_fetch_unit #(
    .ADDR_W    (ADDR_W),
    .RESET_PC  (RESET_PC),
    .BUF_DEPTH (BUF_DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[17:2] ^ 16'hC3A5, ~a[17:2]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  task automatic next_accept(output bit found, output logic [31:0] addr);
    found = 1'b0;
    addr  = '0;
    for (int i = 0; i < 40 && !found; i++) begin
      sample();
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        found = 1'b1;
        addr  = bus.imem_req_addr;
      end
    end
  endtask

  // Let exactly n requests be accepted, then hold the memory not-ready.
  task automatic allow_accepts(input int n, output bit ok);
    int cnt;
    cnt = 0;
    tick();
    ready_force = 1'b1;
    for (int i = 0; i < 40 && cnt < n; i++) begin
      @(negedge clk);
      if (bus.imem_req_valid && bus.imem_req_ready) cnt++;
    end
    ok = (cnt == n);
    tick();
    ready_force = 1'b0;
  endtask

  // In-order memory: response for a request accepted at edge n may appear
  // from the cycle starting at edge n+lat-1 onward, one per cycle.
  task automatic mem_proc();
    bit          acc;
    bit          consumed;
    logic [31:0] acc_addr;
    mreq_t       r;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      acc      = (rst_n === 1'b1) && (bus.imem_req_valid === 1'b1) && (bus.imem_req_ready === 1'b1);
      acc_addr = bus.imem_req_addr;
      consumed = (rst_n === 1'b1) && (bus.imem_rsp_valid === 1'b1);
      @(posedge clk);
      #2;
      bus.imem_req_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
      if (!rst_n) begin
        mq.delete();
        bus.imem_rsp_valid = 1'b0;
      end else begin
        if (consumed && mq.size() > 0) void'(mq.pop_front());
        if (acc) begin
          r.addr = acc_addr;
          r.due  = cyc + lat - 1;
          mq.push_back(r);
        end
        if (mq.size() > 0 && mq[0].due <= cyc) begin
          bus.imem_rsp_valid = 1'b1;
          bus.imem_rsp_data  = mem_word(mq[0].addr);
        end else begin
          bus.imem_rsp_valid = 1'b0;
          bus.imem_rsp_data  = $urandom;
        end
      end
    end
  endtask

  // Program-order model: requests and delivered words follow PC, PC+4, ...
  // restarting at each aligned redirect target; nothing moves after a fault.
  task automatic mon_proc();
    bit          prev_stall;
    logic [31:0] prev_out;
    logic [31:0] prev_pc;
    prev_stall = 1'b0;
    prev_out   = '0;
    prev_pc    = '0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        exp_pc     = RESET_PC;
        exp_req    = RESET_PC;
        m_fault    = 1'b0;
        prev_stall = 1'b0;
        continue;
      end
      if (prev_stall) begin
        chk("hold_valid", bus.instr_valid, 1);
        chk("hold_out", bus.instr_out, prev_out);
        chk("hold_pc", bus.instr_pc, prev_pc);
      end
      if (bus.instr_valid && bus.instr_ready) begin
        chk("stream_pc", bus.instr_pc, exp_pc);
        chk("stream_data", bus.instr_out, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        n_consumed++;
      end
      if (m_fault) begin
        chk("fault_reqv", bus.imem_req_valid, 0);
        chk("fault_ivld", bus.instr_valid, 0);
        chk("fault_flag", bus.fetch_fault, 1);
      end else if (bus.imem_req_valid && bus.imem_req_ready) begin
        chk("req_addr", bus.imem_req_addr, exp_req);
        exp_req = exp_req + 32'd4;
      end
      if (bus.redirect_valid && !m_fault) begin
        if (bus.redirect_target[1:0] == 2'b00) begin
          exp_pc  = bus.redirect_target;
          exp_req = bus.redirect_target;
        end else begin
          m_fault = 1'b1;
        end
      end
      prev_stall = bus.instr_valid && !bus.instr_ready && !bus.redirect_valid;
      prev_out   = bus.instr_out;
      prev_pc    = bus.instr_pc;
    end
  endtask

  initial begin
    #1000000;
    $error("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          found;
    bit          ok;
    logic [31:0] a;
    int          first_acc;
    int          first_vld;
    int          gaps;
    int          n_acc;
    int          base;
    int          bad;

    bus.instr_ready     = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = '0;
    fork
      mem_proc();
      mon_proc();
    join_none

    #2 rst_n = 1'b0;
    repeat (2) sample();

    // Reset values
    chk("rst_req_valid", bus.imem_req_valid, 0);
    chk("rst_instr_valid", bus.instr_valid, 0);
    chk("rst_instr_out", bus.instr_out, 0);
    chk("rst_instr_pc", bus.instr_pc, 0);
    chk("rst_fault", bus.fetch_fault, 0);

    // Streaming with a 1-cycle memory
    lat = 1;
    ready_force = 1'b1;
    bus.instr_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    next_accept(found, a);
    chk("t1_acc_found", found, 1);
    chk("t1_first_addr", a, RESET_PC);
    first_acc = cyc;
    first_vld = -1;
    for (int i = 0; i < 10 && first_vld < 0; i++) begin
      sample();
      if (bus.instr_valid) first_vld = cyc;
    end
    chk("t1_latency", 64'(first_vld - first_acc), 2);
    gaps = 0;
    for (int i = 0; i < 12; i++) begin
      sample();
      if (!bus.instr_valid) gaps++;
    end
    chk("t1_gaps", 64'(gaps), 0);

    // Decode stalled: credit limit stops fetching at BUF_DEPTH
    bus.instr_ready = 1'b0;
    do_reset();
    n_acc = 0;
    for (int i = 0; i < 15; i++) begin
      sample();
      if (bus.imem_req_valid && bus.imem_req_ready) n_acc++;
    end
    chk("t2_accepts", 64'(n_acc), BUF_DEPTH);
    chk("t2_req_valid", bus.imem_req_valid, 0);
    chk("t2_head_valid", bus.instr_valid, 1);
    chk("t2_head_pc", bus.instr_pc, 32'h0);
    tick();
    bus.instr_ready = 1'b1;
    next_accept(found, a);
    chk("t2_resume_found", found, 1);
    chk("t2_resume_addr", a, 32'h10);

    // 3-cycle memory, two stale requests dropped on redirect
    ready_force = 1'b0;
    lat = 3;
    do_reset();
    allow_accepts(2, ok);
    chk("t3_first_pair", ok, 1);
    base = n_consumed;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      sample();
      if (n_consumed >= base + 2) found = 1'b1;
    end
    chk("t3_drained", found, 1);
    allow_accepts(2, ok);
    chk("t3_second_pair", ok, 1);
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h100;
    tick();
    bus.redirect_valid = 1'b0;
    ready_force = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      sample();
      if (bus.instr_valid) found = 1'b1;
    end
    chk("t3_valid_found", found, 1);
    chk("t3_redir_pc", bus.instr_pc, 32'h100);
    chk("t3_redir_data", bus.instr_out, mem_word(32'h100));

    // Redirect, response and decode handshake in the same cycle
    lat = 2;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(posedge clk);
      #3;
      if (bus.imem_rsp_valid && bus.instr_valid) found = 1'b1;
    end
    chk("t4_setup", found, 1);
    base = n_consumed;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h200;
    tick();
    bus.redirect_valid = 1'b0;
    sample();
    chk("t4_consumed_once", 64'(n_consumed - base), 1);
    chk("t4_empty", bus.instr_valid, 0);
    chk("t4_req_valid", bus.imem_req_valid, 1);
    chk("t4_req_addr", bus.imem_req_addr, 32'h200);

    // Misaligned redirect: sticky fault until reset
    tick();
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h102;
    tick();
    bus.redirect_valid = 1'b0;
    sample();
    chk("t5_fault", bus.fetch_fault, 1);
    chk("t5_req_valid", bus.imem_req_valid, 0);
    chk("t5_instr_valid", bus.instr_valid, 0);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      sample();
      if (bus.imem_req_valid || bus.instr_valid || !bus.fetch_fault) bad++;
    end
    chk("t5_stays_faulted", 64'(bad), 0);
    do_reset();
    sample();
    chk("t5_fault_cleared", bus.fetch_fault, 0);
    next_accept(found, a);
    chk("t5_restart_found", found, 1);
    chk("t5_restart_addr", a, RESET_PC);

    // PC wrap at the top of the address space
    tick();
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'hFFFF_FFF8;
    tick();
    bus.redirect_valid = 1'b0;
    next_accept(found, a);
    chk("t6_addr0", a, 32'hFFFF_FFF8);
    next_accept(found, a);
    chk("t6_addr1", a, 32'hFFFF_FFFC);
    next_accept(found, a);
    chk("t6_wrap", a, 32'h0000_0000);

    // Randomized traffic against the stream model
    base = n_consumed;
    rand_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      tick();
      if ($urandom_range(0, 15) == 0) lat = int'($urandom_range(1, 4));
      bus.instr_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) begin
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'($urandom_range(0, 255)) << 2;
      end else begin
        bus.redirect_valid = 1'b0;
      end
    end
    tick();
    bus.redirect_valid = 1'b0;
    bus.instr_ready = 1'b1;
    rand_ready = 1'b0;
    ready_force = 1'b1;
    repeat (30) sample();
    chk("t7_progress", (n_consumed - base) > 30, 1);
    chk("t7_no_fault", bus.fetch_fault, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
